// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the M-extension multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned MD_BIT_W = 32;
    localparam int unsigned MD_CNT_W = $clog2(MD_BIT_W + 1);

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic md_a_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

    function automatic logic md_b_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// with sign fix-up, result select and the divide fast-path results.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int unsigned BIT_W = MD_BIT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             finish_i,
    input  logic [2:0]       funct3_i,
    input  logic [BIT_W-1:0] op_a_i,
    input  logic [BIT_W-1:0] op_b_i,
    output logic             fast_c_o,
    output logic [BIT_W-1:0] result_o
);

    localparam int unsigned PW = 2 * BIT_W;

    logic [2:0]       f3_q, f3_d;
    logic             sign_q, sign_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [BIT_W-1:0] mplier_q, mplier_d;
    logic [BIT_W-1:0] result_q, result_d;

    logic             a_neg, b_neg;
    logic [BIT_W-1:0] mag_a, mag_b;
    logic             div_zero, div_ovf;
    logic [BIT_W-1:0] fast_val;

    assign a_neg = md_a_signed(funct3_i) & op_a_i[BIT_W-1];
    assign b_neg = md_b_signed(funct3_i) & op_b_i[BIT_W-1];
    assign mag_a = a_neg ? -op_a_i : op_a_i;
    assign mag_b = b_neg ? -op_b_i : op_b_i;

    assign div_zero = funct3_i[2] && (op_b_i == '0);
    assign div_ovf  = ((funct3_i == MD_DIV) || (funct3_i == MD_REM)) &&
                      (op_a_i == {1'b1, {(BIT_W-1){1'b0}}}) && (op_b_i == '1);
    assign fast_c_o = div_zero | div_ovf;

    // funct3[1] separates REM/REMU from DIV/DIVU
    always_comb begin
        fast_val = '0;
        if (div_zero) begin
            fast_val = funct3_i[1] ? op_a_i : '1;
        end else begin
            fast_val = funct3_i[1] ? '0 : op_a_i;
        end
    end

    logic [PW-1:0]    mul_acc_n;
    logic [BIT_W:0]   div_tmp;
    logic             div_ge;
    logic [BIT_W-1:0] div_rem_n, div_quo_n;

    // Dividend shifts out of mcand's low half while quotient bits shift in.
    assign mul_acc_n = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign div_tmp   = {acc_q[BIT_W-1:0], mcand_q[BIT_W-1]};
    assign div_ge    = (div_tmp >= {1'b0, mplier_q});
    assign div_rem_n = div_ge ? BIT_W'(div_tmp - {1'b0, mplier_q}) : div_tmp[BIT_W-1:0];
    assign div_quo_n = {mcand_q[BIT_W-2:0], div_ge};

    logic [PW-1:0]    prod_fix;
    logic [BIT_W-1:0] quo_fix, rem_fix, sel;

    assign prod_fix = sign_q ? -mul_acc_n : mul_acc_n;
    assign quo_fix  = sign_q ? -div_quo_n : div_quo_n;
    assign rem_fix  = sign_q ? -div_rem_n : div_rem_n;

    always_comb begin
        sel = rem_fix;
        case (f3_q)
            MD_MUL:                       sel = prod_fix[BIT_W-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: sel = prod_fix[PW-1:BIT_W];
            MD_DIV, MD_DIVU:              sel = quo_fix;
            default:                      sel = rem_fix;
        endcase
    end

    always_comb begin
        f3_d     = f3_q;
        sign_d   = sign_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (load_i) begin
            f3_d     = funct3_i;
            sign_d   = (funct3_i == MD_REM) ? a_neg : (a_neg ^ b_neg);
            mcand_d  = {{BIT_W{1'b0}}, mag_a};
            mplier_d = mag_b;
            acc_d    = '0;
            if (fast_c_o) begin
                result_d = fast_val;
            end
        end else if (step_i) begin
            if (f3_q[2]) begin
                acc_d   = {{BIT_W{1'b0}}, div_rem_n};
                mcand_d = {{BIT_W{1'b0}}, div_quo_n};
            end else begin
                acc_d    = mul_acc_n;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
            end
            if (finish_i) begin
                result_d = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f3_q     <= '0;
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            f3_q     <= f3_d;
            sign_q   <= sign_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage sequencer for RISC-V M-extension ops: stalls the pipe while the
// iterative datapath runs, then presents the result for one capture cycle.
module ex_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned BIT_W = MD_BIT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [BIT_W-1:0] op_a,
    input  logic [BIT_W-1:0] op_b,
    input  logic             flush,
    input  logic             hold,
    output logic             stall_req,
    output logic             done,
    output logic [BIT_W-1:0] result
);

    localparam int unsigned CNT_W = $clog2(BIT_W + 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             load_c, step_c, finish_c, fast_c;

    muldiv_datapath #(
        .BIT_W (BIT_W)
    ) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load_c),
        .step_i   (step_c),
        .finish_i (finish_c),
        .funct3_i (funct3),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .fast_c_o (fast_c),
        .result_o (result)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_c    = 1'b0;
        step_c    = 1'b0;
        finish_c  = 1'b0;
        stall_req = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    load_c    = 1'b1;
                    stall_req = 1'b1;
                    cnt_d     = '0;
                    state_d   = fast_c ? MD_DONE : MD_BUSY;
                end
            end
            MD_BUSY: begin
                stall_req = 1'b1;
                if (flush) begin
                    state_d = MD_IDLE;
                end else begin
                    step_c = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIT_W - 1)) begin
                        finish_c = 1'b1;
                        state_d  = MD_DONE;
                    end
                end
            end
            MD_DONE: begin
                if (flush || !hold) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
        if (!rst_n) begin
            stall_req = 1'b0;
        end
        done_d = (state_d == MD_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed vector table, hand-written
// flush/hold/reset sequences and random ops against an arithmetic model.
module tb_ex_muldiv_ctrl;

    localparam int unsigned W = 32;
    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;
    localparam int LONG = W + 1;

    logic         clk, rst_n, start, flush, hold;
    logic [2:0]   funct3;
    logic [W-1:0] op_a, op_b, result;
    logic         stall_req, done;

    int           n_checks, n_fail;
    logic [W-1:0] last_res;

    ex_muldiv_ctrl #(.BIT_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .hold      (hold),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]   f3;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           stalls;
    } vec_t;

    vec_t vecs[16];

    // Reference: plain 64-bit arithmetic from the RISC-V M rules
    function automatic logic [W-1:0] ref_md(input logic [2:0] f3, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        logic [W-1:0]    r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        r  = '0;
        case (f3)
            F_MUL:    begin up = ua * ub; r = up[31:0]; end
            F_MULH:   begin sp = sa * sb; r = sp[63:32]; end
            F_MULHSU: begin sp = sa * longint'(ub); r = sp[63:32]; end
            F_MULHU:  begin up = ua * ub; r = up[63:32]; end
            F_DIV: begin
                if (b == 0) r = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else begin sp = sa / sb; r = sp[31:0]; end
            end
            F_DIVU: begin
                if (b == 0) r = '1;
                else begin up = ua / ub; r = up[31:0]; end
            end
            F_REM: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                else begin sp = sa % sb; r = sp[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin up = ua % ub; r = up[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic int exp_stalls(input logic [2:0] f3, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == F_DIV || f3 == F_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return LONG;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        #1;
    endtask

    // Operands and funct3 are scrambled after cycle 0; they must be ignored.
    task automatic wait_done(output int stalls, output bit seen);
        stalls = 0;
        seen   = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (stall_req) stalls++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            start  = 1'b0;
            funct3 = 3'($urandom_range(0, 7));
            op_a   = $urandom;
            op_b   = $urandom;
            #1;
        end
    endtask

    task automatic finish_op(input logic [W-1:0] exp, input int exp_st, input string nm);
        int st;
        bit seen;
        wait_done(st, seen);
        check({nm, " done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({nm, " result"}, result, exp);
            check({nm, " stall_cycles"}, 32'(st), 32'(exp_st));
            check({nm, " stall_in_done"}, 32'(stall_req), 32'd0);
        end
        last_res = exp;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int exp_st, input string nm);
        @(negedge clk);
        drive_op(f3, a, b);
        finish_op(exp, exp_st, nm);
        @(negedge clk);
        start = 1'b0;
        #1;
        check({nm, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [2:0]   rf3;
        logic [W-1:0] ra, rb;
        bit           late;

        n_checks = 0;
        n_fail   = 0;
        last_res = '0;

        vecs[0]  = '{F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LONG};
        vecs[1]  = '{F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LONG};
        vecs[2]  = '{F_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LONG};
        vecs[3]  = '{F_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, LONG};
        vecs[4]  = '{F_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LONG};
        vecs[5]  = '{F_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LONG};
        vecs[6]  = '{F_DIVU,   32'd100,        32'd7,         32'd14,        LONG};
        vecs[7]  = '{F_REMU,   32'd100,        32'd7,         32'd2,         LONG};
        vecs[8]  = '{F_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{F_REM,    32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{F_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{F_REMU,   32'd5,          32'd0,         32'd5,         1};
        vecs[14] = '{F_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         LONG};
        vecs[15] = '{F_MUL,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, LONG};

        // Reset with start asserted: nothing may be requested
        rst_n = 1'b0; start = 1'b1; flush = 1'b0; hold = 1'b0;
        funct3 = F_DIV; op_a = 32'd5; op_b = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst stall_req", 32'(stall_req), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        #1;
        check("idle stall_req", 32'(stall_req), 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stalls,
                   $sformatf("vec%0d", i));
        end

        // Back-to-back: next op accepted in the cycle right after DONE
        @(negedge clk);
        drive_op(F_MUL, 32'd3, 32'd5);
        finish_op(32'd15, LONG, "b2b_a");
        @(negedge clk);
        drive_op(F_DIVU, 32'd9, 32'd3);
        check("b2b done_drop", 32'(done), 32'd0);
        check("b2b accept", 32'(stall_req), 32'd1);
        finish_op(32'd3, LONG, "b2b_b");
        @(negedge clk);
        start = 1'b0;
        #1;

        // hold for 3 DONE cycles, start ignored while in DONE
        hold = 1'b1;
        @(negedge clk);
        drive_op(F_REMU, 32'd100, 32'd7);
        finish_op(32'd2, LONG, "hold");
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) hold = 1'b0;
            start  = 1'b1;
            funct3 = F_DIVU;
            op_a   = $urandom;
            op_b   = 32'd0;
            #1;
            check($sformatf("hold done c%0d", k), 32'(done), 32'd1);
            check($sformatf("hold result c%0d", k), result, 32'd2);
            check($sformatf("hold stall c%0d", k), 32'(stall_req), 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        check("hold exit done", 32'(done), 32'd0);
        check("hold exit stall", 32'(stall_req), 32'd0);

        // flush during BUSY iteration 10
        @(negedge clk);
        drive_op(F_MUL, 32'h0001_2345, 32'h0000_0777);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
        end
        check("flush busy stall", 32'(stall_req), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush done", 32'(done), 32'd0);
        check("flush stall", 32'(stall_req), 32'd0);
        check("flush result_kept", result, 32'd2);
        late = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done || stall_req) late = 1'b1;
        end
        check("flush no_late_activity", 32'(late), 32'd0);
        run_op(F_DIVU, 32'd9, 32'd3, 32'd3, LONG, "post_flush");

        // flush beats hold in DONE
        hold = 1'b1;
        @(negedge clk);
        drive_op(F_DIVU, 32'd100, 32'd7);
        finish_op(32'd14, LONG, "fdone");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        hold  = 1'b0;
        start = 1'b0;
        #1;
        check("fdone done", 32'(done), 32'd0);
        check("fdone result_kept", result, 32'd14);

        // flush has priority over start in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = F_MUL; op_a = 32'd2; op_b = 32'd3;
        #1;
        check("fidle stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("fidle not_busy", 32'(stall_req), 32'd0);
        check("fidle done", 32'(done), 32'd0);

        // Random ops against the reference model, biased toward corners
        for (int i = 0; i < 60; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = '1;
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            run_op(rf3, ra, rb, ref_md(rf3, ra, rb), exp_stalls(rf3, ra, rb),
                   $sformatf("rand%0d f3=%0d a=%h b=%h", i, rf3, ra, rb));
        end

        // Reset asserted mid-BUSY aborts the op
        run_op(F_REMU, 32'd100, 32'd7, 32'd2, LONG, "pre_rst");
        @(negedge clk);
        drive_op(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", result, 32'd0);
        check("midrst stall", 32'(stall_req), 32'd0);
        rst_n = 1'b1;
        run_op(F_MUL, 32'd7, 32'd6, 32'd42, LONG, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Sequencer for RISC-V M-extension instructions in the execute stage. Accepts a multiply/divide op held in EX and stalls the pipeline while an iterative one-bit-per-cycle shift-add / restoring-divide datapath runs. Presents a registered result for one EX-capture cycle, then releases the stage. Sits beside the EX ALU; its `stall_req` is ORed into the EX/ID stall, and its `result` is muxed onto the EX ALU-result path.

## Interface
- `BIT_W`, 32, operand/result width; iteration count equals `BIT_W`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  EX holds a valid M-op (opcode OP, funct7 = 0000001).
- `funct3`  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op_a`  in  BIT_W  rs1 value, already forwarded.
- `op_b`  in  BIT_W  rs2 value, already forwarded.
- `flush`  in  1  kill the in-flight op (taken jump/branch).
- `hold`  in  1  downstream stall (MEM/cache); EX cannot advance.
- `stall_req`  out  1  combinational; freeze IF/ID/EX.
- `done`  out  1  registered; `result` valid this cycle.
- `result`  out  BIT_W  registered result.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE:** on `start & !flush`:
  - latch `funct3`, the operand magnitudes, and the result sign;
  - clear counter and accumulator.
  - Enter BUSY, or enter DONE directly for the fast paths below.
- **BUSY:** one iteration per cycle.
  - MUL: add the shifted multiplicand if the multiplier LSB is 1, over a 2·BIT_W product.
  - DIV: restoring subtract/shift on magnitudes.
  - After BIT_W iterations, apply sign fix-up (negate if sign flag), select the low/high half or quotient/remainder into `result`, and go to DONE.
- **Signedness:**
  - MULH: both operands signed.
  - MULHSU: `op_a` signed, `op_b` unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV: quotient sign = sign(a) XOR sign(b).
  - REM: remainder takes the sign of the dividend.
- **Fast paths (IDLE → DONE in one cycle):**
  - divisor 0: DIV/DIVU give all-ones, REM/REMU give `op_a`;
  - signed overflow (a = 100…0, b = −1): DIV gives a, REM gives 0.
- **DONE:**
  - `done` = 1 and `stall_req` = 0, so EX captures `result`.
  - Leave for IDLE when `hold` = 0. While `hold` = 1, remain in DONE with `result` and `done` stable.
- **`stall_req`** = (IDLE & `start` & !`flush`) | BUSY. It is 0 in DONE and 0 while `rst_n` = 0.
- **`flush`** in any state: next state IDLE, `done` = 0, `result` unchanged. `flush` has priority over `start`.
- **Reset:** state IDLE, `done` 0, `result` 0, counter 0, accumulators 0. Reset asserted mid-BUSY aborts the op with no `done`.
- **Back-to-back:** a new op is accepted in the cycle after DONE exits.

## Timing
- Cycle 0: `start` seen in IDLE, `stall_req` = 1, operands latched.
- Cycles 1..BIT_W: BUSY, `stall_req` = 1.
- Cycle BIT_W+1: DONE, `done` = 1.
- Total stall is BIT_W+1 cycles (33 at default). The result is visible BIT_W+1 cycles after `start`.
- Fast path: one stall cycle (cycle 0); DONE in cycle 1.
- `start` is ignored outside IDLE. `op_a`/`op_b` may change after cycle 0 without effect.
- `hold` in IDLE or BUSY has no effect; it matters only in DONE.

## Structure
- **Shared package `muldiv_pkg`:**
  - funct3 encodings (`MD_MUL`..`MD_REMU`);
  - state enum (`MD_IDLE`, `MD_BUSY`, `MD_DONE`);
  - `MD_CNT_W` = $clog2(BIT_W+1).
- **Sub-module `muldiv_datapath`:**
  - operand/accumulator shift registers and the add/subtract step;
  - sign fix-up and result select.
- The FSM, counter, and handshake stay in `ex_muldiv_ctrl`.

## Test plan
- MUL 7 × 0xFFFFFFFD → `result` 0xFFFFFFEB; `stall_req` high exactly 33 cycles; `done` pulses 1 cycle (`hold` = 0).
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, each with a 1-cycle stall; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM of the same → 0.
- `flush` in BUSY iteration 10:
  - IDLE next cycle, no `done`, `stall_req` 0;
  - a following DIVU 9 / 3 → 3 after 33 stall cycles.
- `hold` high for 3 cycles in DONE: `done` and `result` stable for 4 cycles, then IDLE.
- `rst_n` low mid-BUSY: next cycle `done` 0, `result` 0, `stall_req` 0.
